// File: rtl/mod_lpm_mult32_pkg.sv
// mod_lpm_mult32_pkg
// Shared constants and pipeline stage records for the 32x32 -> low-32
// pipelined multiplier.
//   WIDTH   : operand / result width (32)
//   HALF    : half-word width used to split operands (16)
//   LATENCY : edges from accepted start to done (3)
package mod_lpm_mult32_pkg;

    localparam int WIDTH   = 32;
    localparam int HALF    = 16;
    localparam int LATENCY = 3;

    // S1: captured operands of an accepted operation
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    // S2: partial products; the cross terms only matter in their low half
    // because they are shifted up by HALF before the final add.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] ll;
        logic [HALF-1:0]  lh;
        logic [HALF-1:0]  hl;
    } s2_t;

    // S3: truncated sum of the partial products
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
    } s3_t;

endpackage

// File: rtl/mod_lpm_mult32_if.sv
// mod_lpm_mult32_if
// Operation bus of the multiplier.
//   clk_en : global enable, low freezes every register
//   start  : dataa/datab carry a new operation this cycle
//   dataa  : multiplicand (unsigned)
//   datab  : multiplier (unsigned)
//   result : low WIDTH bits of dataa*datab, held between done pulses
//   done   : one-cycle pulse marking result valid
// Handshake: an operation is accepted on a rising edge where start=1,
// clk_en=1 and reset=0; there is no back-pressure, so a new operation may
// be accepted every enabled edge. done=1 after an enabled edge means result
// holds the next in-order product; while clk_en=0 both simply hold.
interface mod_lpm_mult32_if;
    import mod_lpm_mult32_pkg::*;

    logic             clk_en;
    logic             start;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (
        output clk_en, start, dataa, datab,
        input  result, done
    );

    modport slave (
        input  clk_en, start, dataa, datab,
        output result, done
    );

endinterface

// File: rtl/mod_lpm_mult32_mul16x16.sv
// mul16x16
// Combinational unsigned 16x16 -> 32 multiplier used for the partial
// products of the 32-bit multiply.
//   a, b : HALF-bit unsigned operands
//   p    : full WIDTH-bit product
module mul16x16
    import mod_lpm_mult32_pkg::*;
(
    input  logic [HALF-1:0]  a,
    input  logic [HALF-1:0]  b,
    output logic [WIDTH-1:0] p
);

    // Zero-extend first so the product is formed at full width.
    assign p = {{(WIDTH-HALF){1'b0}}, a} * {{(WIDTH-HALF){1'b0}}, b};

endmodule

// File: rtl/mod_lpm_mult32.sv
// mod_lpm_mult32
// Pipelined unsigned multiplier returning the low 32 bits of dataa*datab
// (identical low bits for two's-complement operands).
// Ports:
//   clk             : rising-edge clock
//   reset           : synchronous active-high reset, wins over clk_en
//   bus             : operation bus (slave side), see mod_lpm_mult32_if
//   dbg_stage_valid : {S3, S2, S1} valid bits for observation
// An operation accepted at edge N is captured in S1 at N, its partial
// products in S2 at N+1, its sum in S3 at N+2, and it is presented on
// result/done after edge N+3.
module mod_lpm_mult32
    import mod_lpm_mult32_pkg::*;
#(
    parameter int LATENCY_P = LATENCY,  // only 3 supported
    parameter int WIDTH_P   = WIDTH     // only 32 supported
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_lpm_mult32_if.slave      bus,
    output logic [LATENCY_P-1:0] dbg_stage_valid
);

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic [WIDTH_P-1:0] result_d, result_q;
    logic               done_d, done_q;

    logic [WIDTH-1:0] p_ll;
    logic [WIDTH-1:0] p_lh;
    logic [WIDTH-1:0] p_hl;
    logic [HALF-1:0]  cross_sum;
    logic             unused_cross_hi;

    mul16x16 u_mul_ll (
        .a (s1_q.a[HALF-1:0]),
        .b (s1_q.b[HALF-1:0]),
        .p (p_ll)
    );

    mul16x16 u_mul_lh (
        .a (s1_q.a[HALF-1:0]),
        .b (s1_q.b[WIDTH-1:HALF]),
        .p (p_lh)
    );

    mul16x16 u_mul_hl (
        .a (s1_q.a[WIDTH-1:HALF]),
        .b (s1_q.b[HALF-1:0]),
        .p (p_hl)
    );

    // The upper halves of the cross products land above bit 31 after the
    // shift, so they never reach the result.
    assign unused_cross_hi = ^{p_lh[WIDTH-1:HALF], p_hl[WIDTH-1:HALF]};

    // Carry out of the cross-term add would also land above bit 31.
    assign cross_sum = s2_q.lh + s2_q.hl;

    always_comb begin
        s1_d     = s1_q;
        s2_d     = s2_q;
        s3_d     = s3_q;
        result_d = result_q;
        done_d   = done_q;

        if (bus.clk_en) begin
            // Operand registers only load with start, so idle operand
            // values cannot leak into any stage.
            s1_d.valid = bus.start;
            if (bus.start) begin
                s1_d.a = bus.dataa;
                s1_d.b = bus.datab;
            end

            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.ll = p_ll;
                s2_d.lh = p_lh[HALF-1:0];
                s2_d.hl = p_hl[HALF-1:0];
            end

            s3_d.valid = s2_q.valid;
            if (s2_q.valid) begin
                s3_d.sum = s2_q.ll + {cross_sum, {HALF{1'b0}}};
            end

            // result only moves for a valid op, so it holds across bubbles.
            done_d = s3_q.valid;
            if (s3_q.valid) begin
                result_d = s3_q.sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.done        = done_q;
    assign dbg_stage_valid = {s3_q.valid, s2_q.valid, s1_q.valid};

endmodule

// File: tb/tb_mod_lpm_mult32.sv
// tb_mod_lpm_mult32
// Directed vectors for the pipelined 32-bit multiplier with hand-computed
// expectations, plus an in-order scoreboard fed by the driver and drained
// by a monitor on every enabled edge.
module tb_mod_lpm_mult32;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_valid;

    int n_tests;
    int n_fail;

    logic [31:0] exp_q[$];

    mod_lpm_mult32_if bus ();

    mod_lpm_mult32 dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .dbg_stage_valid (dbg_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = a * b;
        bus.start = 1'b1;
        bus.dataa = a;
        bus.datab = b;
        if (bus.clk_en && !reset) exp_q.push_back(p);
        tick();
        bus.start = 1'b0;
    endtask

    // Start one op and check done timing: low after N+1, N+2, high after N+3.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        do_start(a, b);
        tick();
        check({tag, "_done_n1"}, {31'b0, bus.done}, 32'd0);
        tick();
        check({tag, "_done_n2"}, {31'b0, bus.done}, 32'd0);
        tick();
        check({tag, "_done_n3"}, {31'b0, bus.done}, 32'd1);
        check({tag, "_result"}, bus.result, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic en_s;
        logic rst_s;
        forever begin
            @(posedge clk);
            en_s  = bus.clk_en;
            rst_s = reset;
            #2;
            if (rst_s) begin
                check("mon_rst_done", {31'b0, bus.done}, 32'd0);
                check("mon_rst_result", bus.result, 32'd0);
            end else if (en_s && bus.done) begin
                if (exp_q.size() == 0) begin
                    check("mon_spurious_done", 32'd1, 32'd0);
                end else begin
                    check("mon_result", bus.result, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.clk_en = 1'b0;
        bus.start  = 1'b0;
        bus.dataa  = 32'hDEAD_BEEF;
        bus.datab  = 32'h1234_5678;

        // Reset with clk_en low still clears everything.
        tick();
        tick();
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_valid", {29'b0, dbg_valid}, 32'd0);
        exp_q.delete();
        reset      = 1'b0;
        bus.clk_en = 1'b1;

        // First op accepted on the first edge after reset release.
        run_one("t_1x2", 32'd1, 32'd2, 32'd2);
        tick();
        check("t_1x2_done_once", {31'b0, bus.done}, 32'd0);
        check("t_1x2_hold", bus.result, 32'd2);

        // Back-to-back operations.
        do_start(32'd332, 32'd22);
        do_start(32'd2, 32'd23);
        tick();
        check("b2b_done_early", {31'b0, bus.done}, 32'd0);
        tick();
        check("b2b_done_0", {31'b0, bus.done}, 32'd1);
        check("b2b_result_0", bus.result, 32'd7304);
        tick();
        check("b2b_done_1", {31'b0, bus.done}, 32'd1);
        check("b2b_result_1", bus.result, 32'd46);
        tick();
        check("b2b_done_end", {31'b0, bus.done}, 32'd0);
        check("b2b_hold", bus.result, 32'd46);

        // Truncation boundaries.
        run_one("t_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_one("t_2p32", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_one("t_cross", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
        run_one("t_mixed", 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);

        // Stall for 4 cycles right after the start edge; a start during
        // the stall must be ignored.
        do_start(32'd7, 32'd6);
        bus.clk_en = 1'b0;
        bus.start  = 1'b1;
        bus.dataa  = 32'd9;
        bus.datab  = 32'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_done_low", {31'b0, bus.done}, 32'd0);
        end
        bus.start  = 1'b0;
        bus.clk_en = 1'b1;
        tick();
        check("stall_en1", {31'b0, bus.done}, 32'd0);
        tick();
        check("stall_en2", {31'b0, bus.done}, 32'd0);
        tick();
        check("stall_en3_done", {31'b0, bus.done}, 32'd1);
        check("stall_result", bus.result, 32'd42);
        // Freezing while done is high holds done and result.
        bus.clk_en = 1'b0;
        tick();
        tick();
        check("frozen_done", {31'b0, bus.done}, 32'd1);
        check("frozen_result", bus.result, 32'd42);
        bus.clk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after_stall_no_done", {31'b0, bus.done}, 32'd0);
        end
        check("after_stall_result", bus.result, 32'd42);

        // Reset one cycle after a start discards it.
        do_start(32'd5, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("midrst_result", bus.result, 32'd0);
        check("midrst_valid", {29'b0, dbg_valid}, 32'd0);
        run_one("t_3x3", 32'd3, 32'd3, 32'd9);

        // Operand changes without start do not disturb result.
        for (int i = 0; i < 5; i++) begin
            bus.dataa = $urandom;
            bus.datab = $urandom;
            tick();
        end
        check("idle_operands_done", {31'b0, bus.done}, 32'd0);
        check("idle_operands_result", bus.result, 32'd9);

        // start coinciding with reset is ignored.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.dataa = 32'd4;
        bus.datab = 32'd4;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_start_no_done", {31'b0, bus.done}, 32'd0);
        end
        check("rst_start_result", bus.result, 32'd0);

        // Random start/clk_en traffic checked by the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            bus.clk_en = ($urandom_range(0, 4) != 0);
            bus.dataa  = $urandom;
            bus.datab  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                do_start(bus.dataa, bus.datab);
            end else begin
                tick();
            end
        end
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
